// File: rtl/rf_window_ctrl.sv
// Window-management controller for a windowed register file: tracks CWP/SWP,
// services call/return and spills/fills one window through a req/ack memory port.
module rf_window_ctrl #(
    parameter  int N         = 4,
    parameter  int F         = 4,
    parameter  int AW        = 32,
    parameter  int SP_BASE   = 0,
    parameter  int MAX_SPILL = 255,
    localparam int PW        = $clog2(F),
    localparam int SW        = $clog2(2 * N)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CALL,
    input  logic          RET,
    output logic          READY,
    output logic          DONE,
    output logic          ERR,
    output logic [PW-1:0] CWP,
    output logic [PW-1:0] SWP,
    output logic [PW-1:0] RF_WIN,
    output logic [SW-1:0] RF_SLOT,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    input  logic          MEM_ACK
);

    localparam int SPLW = (MAX_SPILL > 0) ? $clog2(MAX_SPILL + 1) : 1;

    localparam logic [PW:0]   RES_FULL  = (PW + 1)'(F);
    localparam logic [PW:0]   RES_ONE   = (PW + 1)'(1);
    localparam logic [SPLW-1:0] SPL_MAX = SPLW'(MAX_SPILL);
    localparam logic [SW-1:0] SLOT_LAST = SW'(2 * N - 1);
    localparam logic [AW-1:0] WIN_WORDS = AW'(2 * N);
    localparam logic [AW-1:0] SP_RESET  = AW'(SP_BASE);

    typedef enum logic [1:0] {
        IDLE,
        SPILL,
        FILL,
        FIN
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   cwp, cwp_n;
    logic [PW-1:0]   swp, swp_n;
    logic [PW:0]     res, res_n;
    logic [SPLW-1:0] spl, spl_n;
    logic [AW-1:0]   sp, sp_n;
    logic [PW-1:0]   rf_win, rf_win_n;
    logic [SW-1:0]   rf_slot, rf_slot_n;
    logic [AW-1:0]   mem_addr, mem_addr_n;
    logic            done_q, done_n;
    logic            err_q, err_n;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            cwp      <= '0;
            swp      <= '0;
            res      <= RES_ONE;
            spl      <= '0;
            sp       <= SP_RESET;
            rf_win   <= '0;
            rf_slot  <= '0;
            mem_addr <= SP_RESET;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cwp      <= cwp_n;
            swp      <= swp_n;
            res      <= res_n;
            spl      <= spl_n;
            sp       <= sp_n;
            rf_win   <= rf_win_n;
            rf_slot  <= rf_slot_n;
            mem_addr <= mem_addr_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        cwp_n      = cwp;
        swp_n      = swp;
        res_n      = res;
        spl_n      = spl;
        sp_n       = sp;
        rf_win_n   = rf_win;
        rf_slot_n  = rf_slot;
        mem_addr_n = mem_addr;
        done_n     = 1'b0;
        err_n      = 1'b0;

        unique case (state)
            IDLE: begin
                if (CALL && RET) begin
                    err_n = 1'b1;
                end else if (CALL) begin
                    if (res != RES_FULL) begin
                        cwp_n  = cwp + PW'(1);
                        res_n  = res + (PW + 1)'(1);
                        done_n = 1'b1;
                    end else if (spl != SPL_MAX) begin
                        state_n    = SPILL;
                        rf_win_n   = swp;
                        rf_slot_n  = '0;
                        mem_addr_n = sp;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (RET) begin
                    if (res != RES_ONE) begin
                        cwp_n  = cwp - PW'(1);
                        res_n  = res - (PW + 1)'(1);
                        done_n = 1'b1;
                    end else if (spl != '0) begin
                        // Refill the caller's window top-down from the stack top.
                        state_n    = FILL;
                        rf_win_n   = cwp - PW'(1);
                        rf_slot_n  = SLOT_LAST;
                        mem_addr_n = sp - AW'(1);
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            SPILL: begin
                if (MEM_ACK) begin
                    if (rf_slot == SLOT_LAST) begin
                        state_n    = FIN;
                        sp_n       = sp + WIN_WORDS;
                        spl_n      = spl + SPLW'(1);
                        swp_n      = swp + PW'(1);
                        cwp_n      = cwp + PW'(1);
                        rf_slot_n  = '0;
                        mem_addr_n = sp + WIN_WORDS;
                    end else begin
                        rf_slot_n  = rf_slot + SW'(1);
                        mem_addr_n = mem_addr + AW'(1);
                    end
                end
            end

            FILL: begin
                if (MEM_ACK) begin
                    if (rf_slot == '0) begin
                        state_n    = FIN;
                        sp_n       = sp - WIN_WORDS;
                        spl_n      = spl - SPLW'(1);
                        swp_n      = swp - PW'(1);
                        cwp_n      = cwp - PW'(1);
                        mem_addr_n = sp - WIN_WORDS;
                    end else begin
                        rf_slot_n  = rf_slot - SW'(1);
                        mem_addr_n = mem_addr - AW'(1);
                    end
                end
            end

            FIN: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign READY    = (state == IDLE);
    assign DONE     = done_q | (state == FIN);
    assign ERR      = err_q;
    assign MEM_REQ  = (state == SPILL) || (state == FILL);
    assign MEM_WE   = (state == SPILL);
    assign MEM_ADDR = mem_addr;
    assign CWP      = cwp;
    assign SWP      = swp;
    assign RF_WIN   = rf_win;
    assign RF_SLOT  = rf_slot;

endmodule

// File: doc/rf_window_ctrl.md
Name: rf_window_ctrl

Overview:
Window-management controller for the windowed register file. Tracks the current window pointer (CWP) and the oldest resident window pointer (SWP), and accepts subroutine call/return requests. When a call overflows the resident windows, it spills one window (in+local, 2N words) to memory through a req/ack handshake. When a return underflows, it fills one window back from memory. It drives the register file's SUBCALL/SUBRETURN side, the spill/fill slot selection and the memory-side bus control.

Parameters:
N, 4, registers per in/local/out block; one spill/fill moves 2N words
F, 4, number of physical windows; power of 2, >=2
AW, 32, memory word-address width
SP_BASE, 0, memory word address of the first spilled window
MAX_SPILL, 255, maximum number of windows held in memory

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous active-high reset
CALL  in  1  call request; sampled only when READY=1
RET  in  1  return request; sampled only when READY=1
READY  out  1  controller idle, accepts CALL/RET
DONE  out  1  one-cycle pulse when the accepted request has completed
ERR  out  1  one-cycle pulse on a rejected request
CWP  out  clog2(F)  current window pointer
SWP  out  clog2(F)  oldest resident window pointer
RF_WIN  out  clog2(F)  window being spilled or filled
RF_SLOT  out  clog2(2N)  register slot within RF_WIN for the current word
MEM_REQ  out  1  memory transfer request
MEM_WE  out  1  1 = spill (write RF BUSOUT to memory), 0 = fill (memory to RF BUSIN)
MEM_ADDR  out  AW  word address of the current transfer
MEM_ACK  in  1  memory accepted/returned the current word

Behaviour:
- Reset (synchronous, RESET high at a rising edge) aborts any operation immediately. Resulting values:
  - CWP=0, SWP=0, resident count RES=1, spilled count SPL=0, stack pointer SP=SP_BASE.
  - FSM returns to IDLE.
  - READY=1; DONE, ERR, MEM_REQ, MEM_WE=0; MEM_ADDR=SP_BASE; RF_WIN=0; RF_SLOT=0.
  - A partially spilled window is discarded; memory contents are not undone.
- FSM states: IDLE, SPILL, FILL, FIN. READY=1 only in IDLE.
- IDLE, CALL=1 and RET=0:
  - If RES<F: CWP<=CWP+1 (mod F), RES<=RES+1, DONE pulses next cycle (1-cycle latency), stay in IDLE.
  - If RES==F and SPL<MAX_SPILL: go to SPILL with RF_WIN=SWP, RF_SLOT=0, MEM_ADDR=SP.
  - If RES==F and SPL==MAX_SPILL: ERR pulse, no state change.
- IDLE, RET=1 and CALL=0:
  - If RES>1: CWP<=CWP-1 (mod F), RES<=RES-1, DONE next cycle.
  - If RES==1 and SPL>0: go to FILL with RF_WIN=CWP-1 (mod F), RF_SLOT=2N-1, MEM_ADDR=SP-1.
  - If RES==1 and SPL==0: underflow, ERR pulse, no change.
- IDLE, CALL=1 and RET=1 together: ERR pulse, both ignored.
- SPILL (MEM_REQ=1, MEM_WE=1):
  - MEM_ADDR and RF_SLOT are held stable until MEM_ACK=1 is sampled.
  - On each ack: RF_SLOT+1, MEM_ADDR+1.
  - On the ack of slot 2N-1: SP<=SP+2N, SPL+1, SWP<=SWP+1, CWP<=CWP+1 (all mod F where applicable), RES unchanged (=F). Next state FIN.
- FILL (MEM_REQ=1, MEM_WE=0):
  - Descending order; each ack writes the memory word into RF_SLOT of RF_WIN.
  - On each ack: RF_SLOT-1, MEM_ADDR-1.
  - On the ack of slot 0: SP<=SP-2N, SPL-1, SWP<=SWP-1, CWP<=CWP-1, RES stays 1. Next state FIN.
- FIN: MEM_REQ=0, DONE=1 for one cycle, then IDLE.
- MEM_ACK is ignored while MEM_REQ=0. MEM_REQ never drops mid-window except on reset.
- Total latency:
  - Spill or fill: 2N ack cycles plus 1 (FIN).
  - With MEM_ACK tied high: 2N+1 cycles from request to DONE.
- CALL/RET asserted while READY=0 are dropped; the requester must hold or retry.
- Pointer arithmetic wraps modulo F. SP arithmetic is modulo 2^AW. Invariant: SP == SP_BASE + 2N*SPL.

Test Plan:
- Reset, then idle 3 cycles -> CWP=0, SWP=0, READY=1, MEM_REQ=0, MEM_ADDR=SP_BASE, DONE/ERR=0.
- 3 single calls (F=4) -> CWP=1,2,3, SWP=0, each DONE one cycle after request, MEM_REQ never asserted.
- 4th call with MEM_ACK delayed 2 cycles per word:
  - 8 writes at addresses 0..7, RF_WIN=0, slots 0..7.
  - Afterwards CWP=0, SWP=1, DONE after the final ack+1.
  - CALL during the spill is ignored.
- From that state, 4 returns -> first three need no memory (CWP 3,2,1). The 4th fills window 0 from addresses 7..0 (slots 7..0), then CWP=0, SWP=0, SP=SP_BASE.
- Return at reset state -> ERR pulse, CWP unchanged. CALL and RET in the same cycle -> ERR pulse, no change.
- RESET asserted after the 3rd ack of a spill -> next cycle MEM_REQ=0, CWP=0, SWP=0, READY=1. A following call increments CWP normally with no spill.
